// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and default frame width.
// Parity support is selected per build with UART_RX_PARITY_EN.
package uart_pkg;

    localparam int DATA_BITS_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Purpose: two-flop synchroniser for the raw serial line plus falling-edge detector.
// Latency: rx_s lags rx by 2 clk; fall is asserted 2 clk after the line drops.
// Backpressure: none; free-running, idles high out of reset.
module rx_sync (
    input  logic clk,
    input  logic rstn,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta;
    logic rx_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
            rx_d <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx_fsm.sv
// Purpose: UART receive FSM; samples start/data/(parity)/stop on baud ticks, strobes rcv or frame_err.
// Latency: strobe 1 clk after the stop-bit tick; no backpressure, strobes are fire-and-forget.
// Build option: UART_RX_PARITY_EN adds an even-parity bit and the parity_err strobe.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx,
    input  logic                 baud_tick,
    output logic                 baud_ena,
    output logic [DATA_BITS-1:0] data,
    output logic                 rcv,
    output logic                 frame_err,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    logic                 rx_s;
    logic                 fall;
    rx_state_t            state;
    logic [2:0]           cnt;
    logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    rx_sync u_rx_sync (
        .clk  (clk),
        .rstn (rstn),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            cnt       <= 3'd0;
            shreg     <= '0;
            data      <= '0;
            rcv       <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            baud_ena  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rcv       <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state    <= ST_START;
                        baud_ena <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        if (!rx_s) begin
                            state <= ST_DATA;
                            cnt   <= 3'd0;
                        end else begin
                            // Line was high again at mid start bit: treat as a glitch.
                            state    <= ST_IDLE;
                            baud_ena <= 1'b0;
                            busy     <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        cnt   <= cnt + 3'd1;
                        if (cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (baud_tick) begin
                        par_bit <= rx_s;
                        state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_tick) begin
                        if (rx_s) begin
                            data <= shreg;
                            rcv  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err <= (^shreg) ^ par_bit;
`endif
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state    <= ST_IDLE;
                        baud_ena <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    baud_ena <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: serial frames with random payloads against an expected-event queue.
// A small baud generator model supplies ticks (M clk per bit, first tick at M/2 after enable).
module tb_uart_rx_fsm;

    localparam int DB = 8;
    localparam int M  = 16;

    typedef struct {
        bit         ferr;
        logic [7:0] d;
        bit         perr;
    } ev_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          rx = 1'b1;
    logic          baud_tick;
    logic          baud_ena;
    logic [DB-1:0] data;
    logic          rcv;
    logic          frame_err;
    logic          busy;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    int         bg_cnt = 0;
    ev_t        exp_q[$];
    logic [7:0] model_data = 8'h00;

    always #5 clk = ~clk;

    uart_rx_fsm #(.DATA_BITS(DB)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .baud_tick (baud_tick),
        .baud_ena  (baud_ena),
        .data      (data),
        .rcv       (rcv),
        .frame_err (frame_err),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always @(posedge clk) begin
        if (!baud_ena) bg_cnt <= 0;
        else           bg_cnt <= (bg_cnt == M - 1) ? 0 : bg_cnt + 1;
    end
    assign baud_tick = baud_ena && (bg_cnt == M / 2);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every strobe must match the oldest outstanding expected event.
    always @(negedge clk) begin
        if (rstn && (rcv || frame_err)) begin
            chk("excl", 32'(rcv & frame_err), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexp_strobe", 32'({rcv, frame_err}), 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("kind_ferr", 32'(frame_err), 32'(e.ferr));
                if (e.ferr) begin
                    chk("ferr_data_kept", 32'(data), 32'(model_data));
                end else begin
                    chk("rcv_data", 32'(data), 32'(e.d));
                    model_data = e.d;
                end
`ifdef UART_RX_PARITY_EN
                chk("perr", 32'(parity_err), 32'(e.ferr ? 1'b0 : e.perr));
`endif
            end
        end
    end

    task automatic bit_period(input logic v);
        rx = v;
        repeat (M) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
        ev_t e;
        e.ferr = !stop_v;
        e.d    = d;
        e.perr = par_flip;
        exp_q.push_back(e);
        @(negedge clk);
        bit_period(1'b0);
        for (int i = 0; i < DB; i++) bit_period(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_period((^d) ^ par_flip);
`endif
        bit_period(stop_v);
        // Restore a high line so the next start bit produces a fresh edge.
        if (!stop_v) bit_period(1'b1);
        rx = 1'b1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ena", 32'(baud_ena), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ena"}, 32'(baud_ena), 32'd0);
        chk({tag, "_data"}, 32'(data), 32'd0);
        chk({tag, "_rcv"}, 32'(rcv), 32'd0);
        chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0);

        // Short low glitch: start detected, but the mid-bit sample sees a high line.
        @(negedge clk);
        rx = 1'b0;
        repeat (M / 4) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy_hi", 32'(busy), 32'd1);
        repeat (2 * M) @(negedge clk);
        chk("glitch_busy", 32'(busy), 32'd0);
        chk("glitch_ena", 32'(baud_ena), 32'd0);
        chk("glitch_data", 32'(data), 32'(model_data));

        send_frame(8'h81, 1'b0, 1'b0);

        // Break: line held low for two frame times, one frame error only.
        begin
            ev_t e;
            e.ferr = 1'b1; e.d = 8'h00; e.perr = 1'b0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        rx = 1'b0;
        repeat (24 * M) @(negedge clk);
        chk("break_busy", 32'(busy), 32'd0);
        rx = 1'b1;
        repeat (2 * M) @(negedge clk);
        chk("break_idle_busy", 32'(busy), 32'd0);

        // Reset in the middle of bit 4 of 0xFF.
        @(negedge clk);
        bit_period(1'b0);
        for (int i = 0; i < 4; i++) bit_period(1'b1);
        repeat (M / 2) @(negedge clk);
        rstn = 1'b0;
        #1;
        check_all_zero("midrst");
        model_data = 8'h00;
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        repeat (2 * M) @(negedge clk);
        check_all_zero("postrst");
        send_frame(8'h3C, 1'b1, 1'b0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
`endif

        for (int k = 0; k < 12; k++) begin
            logic [7:0] d;
            logic       stop_v;
            logic       pf;
            d      = 8'($urandom_range(0, 255));
            stop_v = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
            pf = 1'($urandom_range(0, 1));
`else
            pf = 1'b0;
`endif
            send_frame(d, stop_v, pf);
            repeat ($urandom_range(0, 2) * M) @(negedge clk);
        end

        for (int w = 0; w < 1000 && exp_q.size() != 0; w++) @(negedge clk);
        chk("q_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- UART receiver core; sits directly downstream of the receive baud generator.
- Synchronises the serial line and detects the start-bit falling edge.
- Drives the baud generator's enable and consumes its mid-bit tick pulses to sample start, data, (parity) and stop bits.
- Delivers the received byte with a one-cycle strobe and error flags to the system side.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first; legal 5..8.

Ports:
- clk  input  1  system clock (100 MHz)
- rstn  input  1  asynchronous active-low reset
- rx  input  1  raw serial line, asynchronous, idle high
- baud_tick  input  1  one-cycle mid-bit pulse from baudgen_rx clk_out
- baud_ena  output  1  enable to baudgen_rx clk_ena; high while a frame is in progress
- data  output  DATA_BITS  last received word; held until the next good frame
- rcv  output  1  one-cycle strobe, data valid
- frame_err  output  1  one-cycle strobe, stop bit sampled 0
- busy  output  1  high from start-edge detection until return to IDLE

Behaviour:
- Reset (rstn=0, async): state=IDLE; baud_ena=0, data=0, rcv=0, frame_err=0, busy=0; synchroniser flops=1; bit counter=0.
- Input path:
  - rx passes through 2 flops (rx_s); a third flop gives rx_d.
  - Falling edge = rx_d & ~rx_s.
  - Line-to-detect latency is 3 clk.
- States: IDLE, START, DATA, STOP (plus PARITY when the optional feature is compiled in).
- IDLE:
  - baud_ena=0.
  - On a falling edge -> START; baud_ena=1 and busy=1 from the next cycle.
- START:
  - Wait for baud_tick. The generator's first tick lands at mid start bit (M/2+1 clk after enable).
  - On tick with rx_s=0 -> DATA, bit counter=0.
  - On tick with rx_s=1 -> false start -> IDLE, baud_ena=0, no strobe.
- DATA:
  - On each tick, shift rx_s into the MSB of the shift register (LSB first on the line) and increment the counter.
  - After DATA_BITS ticks -> STOP.
- STOP:
  - On tick with rx_s=1: data<=shift register, rcv=1 for exactly one cycle.
  - On tick with rx_s=0: frame_err=1 for one cycle; data unchanged.
  - Either way -> IDLE, and baud_ena drops in the same cycle the strobe is asserted.
- Ticks outside START/DATA/STOP are ignored.
- The falling-edge detector is ignored outside IDLE.
- A new frame may start the cycle after returning to IDLE. Back-to-back frames need no idle gap beyond the stop-bit remainder.
- Line held low (break): stop bit fails -> frame_err; no new edge is seen until the line goes high then low again.
- rstn asserted mid-frame: immediate abort to reset values; no strobe; partial data is discarded.
- rcv and frame_err are never high in the same cycle. Both are registered outputs.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - PARITY state between DATA and STOP; samples the even-parity bit on a tick.
  - Extra output parity_err (1 bit, reset 0), a one-cycle strobe with the same timing as rcv when XOR(data bits, parity bit)=1.
  - On a parity error, data is still updated and rcv still asserted.
  - Stop-bit rules are unchanged.
- Undefined: no PARITY state, no parity_err port; frame is start+DATA_BITS+stop.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit);
  - default DATA_BITS.
- Baud divisor constants stay in baudgen.vh.
- One natural sub-module: rx_sync (2-flop synchroniser + edge detector; outputs rx_s and fall).
- baudgen_rx is instantiated alongside by the parent uart top, not inside this block.

Test Plan:
- Send 0x55 at 115200 (M=868, ticks from a real baudgen_rx) -> one rcv pulse, data=0x55, busy low after stop; baud_ena low afterwards.
- Send 0xA3 then 0x0F back-to-back with a 1-bit stop only -> two rcv pulses ~10*868 clk apart, data=0xA3 then 0x0F.
- Low glitch of 200 clk on idle rx -> START entered, tick sees rx=1 -> IDLE; no rcv, no frame_err, data unchanged.
- Frame 0x81 with stop bit forced 0 -> frame_err single pulse, rcv=0, data retains the previous value.
- Assert rstn=0 during bit 4 of 0xFF, release, then send 0x3C -> outputs zero during reset, no strobe for the aborted frame, then data=0x3C with rcv.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> rcv, parity_err=0; same frame with parity bit 0 -> rcv and parity_err in the same cycle.
